// File: rtl/stepmotor_drv.sv
// Phase sequencer for 4-wire unipolar steppers: wave, two-phase full-step and
// half-step excitation, prescaled step period, finite or continuous moves.
module stepmotor_drv #(
    parameter int TICK_DIV = 50000,
    parameter int PERIOD_W = 8,
    parameter int STEPS_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [STEPS_W-1:0]  steps,
    input  logic                hold,
    output logic [3:0]          coil,
    output logic                busy,
    output logic                done,
    output logic [STEPS_W-1:0]  step_cnt
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_r;
    logic [2:0]          idx_r;
    logic [PRESC_W-1:0]  presc_r;
    logic [PERIOD_W-1:0] per_cnt_r;
    logic                dir_r;
    logic [1:0]          mode_r;
    logic [PERIOD_W-1:0] period_r;
    logic [STEPS_W-1:0]  steps_r;

    logic                tick_s;
    logic [PERIOD_W-1:0] per_last_s;
    logic                step_due_s;
    logic [2:0]          step_inc_s;
    logic [2:0]          step_idx_s;
    logic                last_step_s;
    logic [1:0]          mode_eff_s;
    logic [2:0]          align_idx_s;

    function automatic logic [3:0] phase(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            3'd7:    p = 4'b1001;
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    // Step timing, next phase index and start-of-move alignment
    always_comb begin
        tick_s     = (presc_r == PRESC_W'(TICK_DIV - 1));
        if (period_r == {PERIOD_W{1'b0}}) begin
            per_last_s = {PERIOD_W{1'b0}};
        end else begin
            per_last_s = period_r - PERIOD_W'(1);
        end
        step_due_s = tick_s && (per_cnt_r == per_last_s);
        if (mode_r == 2'd2) begin
            step_inc_s = 3'd1;
        end else begin
            step_inc_s = 3'd2;
        end
        if (dir_r) begin
            step_idx_s = idx_r + step_inc_s;
        end else begin
            step_idx_s = idx_r - step_inc_s;
        end
        last_step_s = (steps_r != {STEPS_W{1'b0}}) &&
                      ((step_cnt + STEPS_W'(1)) == steps_r);
        if (mode == 2'd3) begin
            mode_eff_s = 2'd0;
        end else begin
            mode_eff_s = mode;
        end
        case (mode_eff_s)
            2'd0:    align_idx_s = {idx_r[2:1], 1'b0};
            2'd1:    align_idx_s = {idx_r[2:1], 1'b1};
            default: align_idx_s = idx_r;
        endcase
    end

    // IDLE/RUN sequencer with registered coil, busy, done and step count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 3'd0;
            presc_r   <= {PRESC_W{1'b0}};
            per_cnt_r <= {PERIOD_W{1'b0}};
            dir_r     <= 1'b0;
            mode_r    <= 2'd0;
            period_r  <= {PERIOD_W{1'b0}};
            steps_r   <= {STEPS_W{1'b0}};
            coil      <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_cnt  <= {STEPS_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        state_r   <= RUN;
                        busy      <= 1'b1;
                        step_cnt  <= {STEPS_W{1'b0}};
                        presc_r   <= {PRESC_W{1'b0}};
                        per_cnt_r <= {PERIOD_W{1'b0}};
                        dir_r     <= dir;
                        mode_r    <= mode_eff_s;
                        period_r  <= period;
                        steps_r   <= steps;
                        idx_r     <= align_idx_s;
                        coil      <= phase(align_idx_s);
                    end else begin
                        coil <= hold ? phase(idx_r) : 4'b0000;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        coil    <= hold ? phase(idx_r) : 4'b0000;
                    end else begin
                        presc_r <= tick_s ? {PRESC_W{1'b0}} : presc_r + PRESC_W'(1);
                        if (tick_s) begin
                            per_cnt_r <= step_due_s ? {PERIOD_W{1'b0}} : per_cnt_r + PERIOD_W'(1);
                        end
                        if (step_due_s) begin
                            idx_r    <= step_idx_s;
                            step_cnt <= step_cnt + STEPS_W'(1);
                            if (last_step_s) begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                coil    <= hold ? phase(step_idx_s) : 4'b0000;
                            end else begin
                                coil <= phase(step_idx_s);
                            end
                        end else begin
                            coil <= phase(idx_r);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    coil    <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepmotor_drv.sv
// Randomised and directed bench for stepmotor_drv against a time-based model.
module tb_stepmotor_drv;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  period = 8'd1;
    logic [15:0] steps = 16'd0;
    logic        hold = 1'b0;
    logic [3:0]  coil;
    logic        busy;
    logic        done;
    logic [15:0] step_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};

    // model state
    int m_idx, m_cnt, m_t, l_dir, l_mode, l_p, l_n;
    bit m_busy, m_done;
    logic [3:0] m_coil;

    stepmotor_drv #(.TICK_DIV(TD), .PERIOD_W(8), .STEPS_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .mode(mode), .period(period), .steps(steps), .hold(hold),
        .coil(coil), .busy(busy), .done(done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; m_t = 0; m_busy = 0; m_done = 0; m_coil = 4'b0000;
    endtask

    // Outputs follow from elapsed cycles since start: step k lands at k*P*TD.
    task automatic model_edge();
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (!m_busy) begin
            if (start && !stop) begin
                m_busy = 1; m_t = 0; m_cnt = 0;
                l_dir = dir;
                l_mode = (mode == 2'd3) ? 0 : int'(mode);
                l_p = (period == 8'd0) ? 1 : int'(period);
                l_n = int'(steps);
                if (l_mode == 0) m_idx = m_idx - (m_idx % 2);
                else if (l_mode == 1) m_idx = m_idx - (m_idx % 2) + 1;
            end
        end else if (stop) begin
            m_busy = 0; m_done = 1;
        end else begin
            m_t++;
            if (m_t % (l_p * TD) == 0) begin
                s = (l_mode == 2) ? 1 : 2;
                m_idx = (m_idx + (l_dir ? s : 8 - s)) % 8;
                m_cnt = (m_cnt + 1) % 65536;
                if (l_n != 0 && m_cnt == l_n) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
        m_coil = (m_busy || hold) ? tbl[m_idx] : 4'b0000;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("coil", 32'(coil), 32'(m_coil));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic go(input logic d, input logic [1:0] md, input logic [7:0] p, input logic [15:0] n);
        dir = d; mode = md; period = p; steps = n; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        cycles(3);
        chk("rst_coil", 32'(coil), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        hold = 1'b1;
        cycle();

        // half-step forward, P=2, N=3
        go(1'b1, 2'd2, 8'd2, 16'd3);
        chk("tp1_t0", 32'(coil), 32'b0001);
        cycles(8);  chk("tp1_s1", 32'(coil), 32'b0011);
        cycles(8);  chk("tp1_s2", 32'(coil), 32'b0010);
        cycles(8);  chk("tp1_s3", 32'(coil), 32'b0110);
        chk("tp1_done", 32'(done), 32'h1);
        chk("tp1_busy", 32'(busy), 32'h0);
        chk("tp1_cnt", 32'(step_cnt), 32'd3);
        cycle();    chk("tp1_done_off", 32'(done), 32'h0);

        // wave reverse, idx 3 aligns to 2, then 0, then 6
        go(1'b0, 2'd0, 8'd1, 16'd2);
        chk("tp2_align", 32'(coil), 32'b0010);
        cycles(4);  chk("tp2_s1", 32'(coil), 32'b0001);
        cycles(4);  chk("tp2_s2", 32'(coil), 32'b1000);
        chk("tp2_done", 32'(done), 32'h1);
        cycle();

        // continuous full-step, stop on a step-due edge
        go(1'b1, 2'd1, 8'd1, 16'd0);
        chk("tp3_align", 32'(coil), 32'b1001);
        cycles(4);  chk("tp3_s1", 32'(coil), 32'b0011);
        cycles(4);  chk("tp3_s2", 32'(coil), 32'b0110);
        start = 1'b1; cycle(); start = 1'b0;   // ignored in RUN
        cycles(2);
        stop = 1'b1; cycle(); stop = 1'b0;
        chk("tp3_stop_coil", 32'(coil), 32'b0110);
        chk("tp3_stop_done", 32'(done), 32'h1);
        chk("tp3_stop_cnt", 32'(step_cnt), 32'd2);
        cycles(6);

        // hold=0, period=0 as 1
        hold = 1'b0;
        cycle();    chk("tp4_idle_off", 32'(coil), 32'b0000);
        go(1'b1, 2'd2, 8'd0, 16'd1);
        cycles(3);  chk("tp4_run", 32'(coil), 32'b0110);
        cycle();    chk("tp4_end_off", 32'(coil), 32'b0000);
        chk("tp4_done", 32'(done), 32'h1);

        // stop in IDLE, start+stop in IDLE
        stop = 1'b1; cycle(); stop = 1'b0;
        chk("tp5_stop_idle", 32'(done), 32'h0);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        chk("tp5_both", 32'(busy), 32'h0);

        // reset mid-move is asynchronous
        go(1'b1, 2'd2, 8'd1, 16'd0);
        cycles(9);
        rst = 1'b1;
        #1;
        chk("tp6_coil", 32'(coil), 32'h0);
        chk("tp6_busy", 32'(busy), 32'h0);
        chk("tp6_done", 32'(done), 32'h0);
        chk("tp6_cnt", 32'(step_cnt), 32'h0);
        cycle();
        rst = 1'b0;
        cycle();
        go(1'b1, 2'd2, 8'd1, 16'd1);
        chk("tp6_restart", 32'(coil), 32'b0001);
        cycles(4);

        // randomised traffic
        for (int i = 0; i < 4000; i++) begin
            start  = ($urandom_range(0, 7) == 0);
            stop   = ($urandom_range(0, 39) == 0);
            dir    = 1'($urandom);
            mode   = 2'($urandom);
            period = 8'($urandom_range(0, 3));
            steps  = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
